// File: rtl/sha_msg_sched_pkg.sv
// Shared definitions for the SHA-256 message-schedule expander:
// word/array sizes, FSM state type, schedule index landmarks and the
// small sigma functions used by the expansion recurrence.
package sha_msg_sched_pkg;

  localparam int unsigned WORD_S   = 32;
  localparam int unsigned W_BLKCNT = 32;
  localparam int unsigned WARR_S   = WORD_S * W_BLKCNT;
  localparam int unsigned W_TOTAL  = 2 * W_BLKCNT;
  localparam int unsigned MSG_WORDS = 16;
  localparam int unsigned MSG_S    = WORD_S * MSG_WORDS;

  typedef logic [WORD_S-1:0] word_t;
  typedef logic [5:0]        sched_idx_t;

  typedef enum logic {
    S_IDLE,
    S_EXPAND
  } sched_state_t;

  // First computed word, last word of the low half, last word overall
  localparam sched_idx_t IDX_FIRST   = 6'd16;
  localparam sched_idx_t IDX_LO_DONE = 6'd31;
  localparam sched_idx_t IDX_LAST    = 6'd63;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_S - n));
  endfunction

  // sigma0: ROTR7 ^ ROTR18 ^ SHR3
  function automatic word_t sig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  // sigma1: ROTR17 ^ ROTR19 ^ SHR10
  function automatic word_t sig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha_msg_sched_word.sv
// Combinational schedule-word generator:
// W[t] = sig1(W[t-2]) + W[t-7] + sig0(W[t-15]) + W[t-16], mod 2^32.
// Kept separate so the adder tree can be timed and tested on its own.
module sha_msg_sched_word
  import sha_msg_sched_pkg::*;
(
  input  logic [WORD_S-1:0] w_m2,
  input  logic [WORD_S-1:0] w_m7,
  input  logic [WORD_S-1:0] w_m15,
  input  logic [WORD_S-1:0] w_m16,
  output logic [WORD_S-1:0] w_new
);

  word_t sum_a;
  word_t sum_b;

  // Two balanced partial sums, then the final add; carries out are dropped
  always_comb begin
    sum_a = sig1(w_m2) + w_m7;
    sum_b = sig0(w_m15) + w_m16;
    w_new = sum_a + sum_b;
  end

endmodule

// File: rtl/sha_msg_sched.sv
// SHA-256 message-schedule expander. Loads one 512-bit block into
// W[0..15] and generates W[16..63] one word per cycle. Both halves of
// the schedule are driven straight from the word registers; en_lo
// marks W[0..31] final, en_hi marks the whole schedule final.
module sha_msg_sched
  import sha_msg_sched_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [MSG_S-1:0]  M,
  output logic              busy,
  output logic [WARR_S-1:0] W_lo,
  output logic [WARR_S-1:0] W_hi,
  output logic              en_lo,
  output logic              en_hi
);

  word_t        w [W_TOTAL];
  sched_idx_t   idx;
  sched_state_t state;
  word_t        w_new;

  sched_idx_t idx_m2;
  sched_idx_t idx_m7;
  sched_idx_t idx_m15;
  sched_idx_t idx_m16;

  // Operand indices; idx >= 16 whenever the result is used, so no underflow
  always_comb begin
    idx_m2  = idx - 6'd2;
    idx_m7  = idx - 6'd7;
    idx_m15 = idx - 6'd15;
    idx_m16 = idx - 6'd16;
  end

  sha_msg_sched_word u_word (
    .w_m2  (w[idx_m2]),
    .w_m7  (w[idx_m7]),
    .w_m15 (w[idx_m15]),
    .w_m16 (w[idx_m16]),
    .w_new (w_new)
  );

  // Pack the word registers onto the two half-schedule buses
  always_comb begin
    W_lo = '0;
    W_hi = '0;
    for (int unsigned i = 0; i < W_BLKCNT; i++) begin
      W_lo[WORD_S*i +: WORD_S] = w[i];
      W_hi[WORD_S*i +: WORD_S] = w[i + W_BLKCNT];
    end
  end

  assign busy = (state == S_EXPAND);

  // Block load, per-cycle expansion and half-done pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < W_TOTAL; i++) begin
        w[i] <= '0;
      end
      idx   <= '0;
      state <= S_IDLE;
      en_lo <= 1'b0;
      en_hi <= 1'b0;
    end else begin
      en_lo <= 1'b0;
      en_hi <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en) begin
            for (int unsigned i = 0; i < MSG_WORDS; i++) begin
              w[i] <= M[WORD_S*i +: WORD_S];
            end
            idx   <= IDX_FIRST;
            state <= S_EXPAND;
          end
        end
        S_EXPAND: begin
          w[idx] <= w_new;
          // idx wraps to 0 after the last word; its value is unused in IDLE
          idx    <= idx + 6'd1;
          if (idx == IDX_LO_DONE) begin
            en_lo <= 1'b1;
          end
          if (idx == IDX_LAST) begin
            en_hi <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_msg_sched.sv
// Self-checking bench for sha_msg_sched: randomized and directed blocks
// compared against a straightforward array-based schedule model, plus a
// full SHA-256 compression of "abc" using the DUT schedule.
module tb_sha_msg_sched;

  logic          clk;
  logic          reset;
  logic          en;
  logic [511:0]  M;
  logic          busy;
  logic [1023:0] W_lo;
  logic [1023:0] W_hi;
  logic          en_lo;
  logic          en_hi;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] ref_w [64];

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  sha_msg_sched dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .M     (M),
    .busy  (busy),
    .W_lo  (W_lo),
    .W_hi  (W_hi),
    .en_lo (en_lo),
    .en_hi (en_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit (passed %0d of %0d)", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] dut_word(input int i);
    if (i < 32) return W_lo[32*i +: 32];
    return W_hi[32*(i-32) +: 32];
  endfunction

  // Reference schedule straight from the recurrence definition
  function automatic void compute_ref(input logic [511:0] m);
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) ref_w[i] = m[32*i +: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(ref_w[t-15], 7) ^ ror(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3);
      s1 = ror(ref_w[t-2], 17) ^ ror(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10);
      ref_w[t] = s1 + ref_w[t-7] + s0 + ref_w[t-16];
    end
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] m;
    for (int i = 0; i < 16; i++) m[32*i +: 32] = $urandom;
    return m;
  endfunction

  // Present a block with en for one edge (E0); returns just after E0
  task automatic start_block(input logic [511:0] m, input string tag);
    M  = m;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    chk({tag, "_busy_E0"}, 32'(busy), 32'd1);
  endtask

  // Follow an accepted block to completion, checking pulse timing each
  // cycle and the full schedule in the en_hi cycle. Optional stray en
  // pulses mid-run, and optional back-to-back start of the next block.
  task automatic run_block(input logic [511:0] m, input bit poke, input bit chain,
                           input logic [511:0] next_m, input string tag);
    compute_ref(m);
    for (int k = 1; k <= 48; k++) begin
      if (poke && (k == 5 || k == 30)) begin
        en = 1'b1;
        M  = ~m;
      end
      @(posedge clk); #1;
      en = 1'b0;
      chk({tag, "_en_lo"}, 32'(en_lo), 32'(k == 16));
      chk({tag, "_en_hi"}, 32'(en_hi), 32'(k == 48));
      chk({tag, "_busy"},  32'(busy),  32'(k != 48));
    end
    for (int i = 0; i < 64; i++) chk($sformatf("%s_W%0d", tag, i), dut_word(i), ref_w[i]);
    if (chain) start_block(next_m, {tag, "_chain"});
  endtask

  task automatic check_abc_hash();
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1, chv, mj;
    a = IV[0]; b = IV[1]; c = IV[2]; d = IV[3];
    e = IV[4]; f = IV[5]; g = IV[6]; h = IV[7];
    for (int t = 0; t < 64; t++) begin
      s1  = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
      chv = (e & f) ^ (~e & g);
      t1  = h + s1 + chv + K[t] + dut_word(t);
      s0  = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
      mj  = (a & b) ^ (a & c) ^ (b & c);
      t2  = s0 + mj;
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    chk("abc_digest_H0", a + IV[0], 32'hba7816bf);
    chk("abc_digest_H7", h + IV[7], 32'hf20015ad);
  endtask

  logic [511:0] abc_blk;
  logic [511:0] blk_a;
  logic [511:0] blk_b;

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    M     = '0;
    abc_blk = '0;
    abc_blk[31:0]    = 32'h61626380;
    abc_blk[511:480] = 32'h00000018;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_en_lo", 32'(en_lo), 32'd0);
    chk("rst_en_hi", 32'(en_hi), 32'd0);
    for (int i = 0; i < 64; i++) chk($sformatf("rst_W%0d", i), dut_word(i), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: NIST "abc" block
    start_block(abc_blk, "abc");
    run_block(abc_blk, 1'b0, 1'b0, '0, "abc");
    chk("abc_W16_const", dut_word(16), 32'h61626380);
    chk("abc_W17_const", dut_word(17), 32'h000F0000);
    check_abc_hash();

    // 2: all-zero then all-ones, back-to-back via en in the en_hi cycle
    @(posedge clk); #1;
    start_block('0, "zero");
    run_block('0, 1'b0, 1'b1, '1, "zero");
    run_block('1, 1'b0, 1'b0, '0, "ones");

    // 3: stray en pulses during expansion are ignored
    blk_a = rand_block();
    start_block(blk_a, "poke");
    run_block(blk_a, 1'b1, 1'b0, '0, "poke");

    // 4: reset mid-expansion
    start_block(abc_blk, "rstmid");
    repeat (19) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    chk("rstmid_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 64; i++) chk($sformatf("rstmid_W%0d", i), dut_word(i), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      chk("rstmid_no_en_hi", 32'(en_hi), 32'd0);
      chk("rstmid_idle",     32'(busy),  32'd0);
    end
    start_block(abc_blk, "abc2");
    run_block(abc_blk, 1'b0, 1'b0, '0, "abc2");

    // 5: idle hold for 100 cycles
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      chk("hold_en_lo", 32'(en_lo), 32'd0);
      chk("hold_en_hi", 32'(en_hi), 32'd0);
      chk("hold_busy",  32'(busy),  32'd0);
    end
    for (int i = 0; i < 64; i++) chk($sformatf("hold_W%0d", i), dut_word(i), ref_w[i]);

    // Random blocks, alternately chained and spaced
    blk_a = rand_block();
    start_block(blk_a, "rnd0");
    for (int n = 1; n <= 6; n++) begin
      blk_b = rand_block();
      if (n % 2 == 0) begin
        run_block(blk_a, 1'b0, 1'b1, blk_b, $sformatf("rnd%0d", n - 1));
      end else begin
        run_block(blk_a, 1'b0, 1'b0, '0, $sformatf("rnd%0d", n - 1));
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        start_block(blk_b, $sformatf("rnd%0d", n));
      end
      blk_a = blk_b;
    end
    run_block(blk_a, 1'b0, 1'b0, '0, "rnd_last");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
